// File: rtl/cyt_rdma_deadlock_pkg.sv
// -----------------------------------------------------------------------------
// cyt_rdma_deadlock_pkg
//   Shared types for the cyt_rdma dataflow deadlock reporter.
//   - state_e  : reporter FSM states (IDLE, REPORT, HOLD)
//   - MON_ID_W : width of the reported monitor index (up to 32 monitors)
//   - report_t : latched report word {mon_id, stamp}
//   Optional feature macro used by the top: CYT_RDMA_DEADLOCK_MASK_EN.
// -----------------------------------------------------------------------------
package cyt_rdma_deadlock_pkg;

    localparam int MON_ID_W    = 5;
    localparam int RPT_STAMP_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REPORT = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    typedef struct packed {
        logic [MON_ID_W-1:0]    mon_id;
        logic [RPT_STAMP_W-1:0] stamp;
    } report_t;

    function automatic report_t make_report(input logic [MON_ID_W-1:0]    id,
                                            input logic [RPT_STAMP_W-1:0] st);
        report_t r;
        r.mon_id = id;
        r.stamp  = st;
        return r;
    endfunction

endpackage

// File: rtl/cyt_rdma_deadlock_qual_cnt.sv
// -----------------------------------------------------------------------------
// cyt_rdma_deadlock_qual_cnt
//   One saturating consecutive-block counter with threshold compare.
//   Ports:
//     clock, reset  : clock, asynchronous active-low reset
//     blk           : effective block input of this monitor
//     en            : count enable (reporter is armed)
//     clr           : synchronous clear of the counter (wins over en)
//     threshold     : qualifying run length; 0 disables the hit
//     hit           : counter has reached a non-zero threshold
// -----------------------------------------------------------------------------
module cyt_rdma_deadlock_qual_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             blk,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] threshold,
    output logic             hit
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: cnt_d gets a default before any branch so every path assigns
        // it; a missing default would infer a latch.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (!blk) begin
                cnt_d = '0;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Threshold is compared live, so a change takes effect at the very next
    // decision edge.
    assign hit = (threshold != '0) && (cnt_q >= threshold);

endmodule

// File: rtl/cyt_rdma_hls_deadlock_reporter.sv
// -----------------------------------------------------------------------------
// cyt_rdma_hls_deadlock_reporter
//   Qualifies sustained `block` from the per-process deadlock monitors, latches
//   the first (lowest-index) offender, emits one report word over valid/ready
//   and holds a sticky deadlock flag until software pulses clear.
//   Ports:
//     clock, reset        : clock, asynchronous active-low reset
//     mon_block[NUM_MON]  : block output of each monitor
//     mon_mask[NUM_MON]   : per-monitor mask (only with CYT_RDMA_DEADLOCK_MASK_EN)
//     threshold[CNT_W]    : consecutive-cycle qualification threshold (0 = off)
//     clear               : re-arm pulse (ignored while a report is pending)
//     rpt_valid/rpt_ready : report handshake
//     rpt_mon_id, rpt_stamp : report payload
//     deadlock            : sticky deadlock flag
//     block_any           : registered OR of the (unmasked) block inputs
//   Optional feature: define CYT_RDMA_DEADLOCK_MASK_EN to add mon_mask.
//   STAMP_W must not exceed 32 (width of the report word stamp field).
// -----------------------------------------------------------------------------
module cyt_rdma_hls_deadlock_reporter
    import cyt_rdma_deadlock_pkg::*;
#(
    parameter int NUM_MON = 8,
    parameter int CNT_W   = 16,
    parameter int STAMP_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_MON-1:0]  mon_block,
`ifdef CYT_RDMA_DEADLOCK_MASK_EN
    input  logic [NUM_MON-1:0]  mon_mask,
`endif
    input  logic [CNT_W-1:0]    threshold,
    input  logic                clear,
    output logic                rpt_valid,
    input  logic                rpt_ready,
    output logic [MON_ID_W-1:0] rpt_mon_id,
    output logic [STAMP_W-1:0]  rpt_stamp,
    output logic                deadlock,
    output logic                block_any
);

    state_e               state_q;
    report_t              rpt_q;
    logic                 rpt_valid_q;
    logic                 deadlock_q;
    logic                 block_any_q;
    logic [STAMP_W-1:0]   stamp_q;

    logic [NUM_MON-1:0]   blk_eff;
    logic [NUM_MON-1:0]   hit;
    logic                 any_hit;
    logic [MON_ID_W-1:0]  hit_idx;
    logic                 cnt_en;
    logic                 cnt_clr;

`ifdef CYT_RDMA_DEADLOCK_MASK_EN
    assign blk_eff = mon_block & ~mon_mask;
`else
    assign blk_eff = mon_block;
`endif

    // Counters run only while armed; clear is honoured everywhere except
    // during a pending report, which must complete first.
    assign cnt_en  = (state_q == ST_IDLE);
    assign cnt_clr = clear && (state_q != ST_REPORT);

    for (genvar g = 0; g < NUM_MON; g++) begin : g_mon
        cyt_rdma_deadlock_qual_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clock     (clock),
            .reset     (reset),
            .blk       (blk_eff[g]),
            .en        (cnt_en),
            .clr       (cnt_clr),
            .threshold (threshold),
            .hit       (hit[g])
        );
    end

    // Priority encoder: scanning downwards lets the lowest index win.
    always_comb begin
        any_hit = 1'b0;
        hit_idx = '0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (hit[i]) begin
                any_hit = 1'b1;
                hit_idx = MON_ID_W'(i);
            end
        end
    end

    // Free-running stamp and block_any.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stamp_q     <= '0;
            block_any_q <= 1'b0;
        end else begin
            stamp_q     <= stamp_q + STAMP_W'(1);
            block_any_q <= |blk_eff;
        end
    end

    // Reporter FSM with registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rpt_q       <= '0;
            rpt_valid_q <= 1'b0;
            deadlock_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A clear in the same cycle re-zeroes the counters, so it
                    // also suppresses detection for that cycle.
                    if (any_hit && !clear) begin
                        rpt_q       <= make_report(hit_idx, RPT_STAMP_W'(stamp_q));
                        rpt_valid_q <= 1'b1;
                        deadlock_q  <= 1'b1;
                        state_q     <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    if (rpt_ready) begin
                        rpt_valid_q <= 1'b0;
                        state_q     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (clear) begin
                        deadlock_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rpt_valid  = rpt_valid_q;
    assign rpt_mon_id = rpt_q.mon_id;
    assign rpt_stamp  = rpt_q.stamp[STAMP_W-1:0];
    assign deadlock   = deadlock_q;
    assign block_any  = block_any_q;

endmodule

// File: tb/tb_cyt_rdma_hls_deadlock_reporter.sv
// -----------------------------------------------------------------------------
// tb_cyt_rdma_hls_deadlock_reporter
//   Directed scenarios plus a randomized run against a behavioural model that
//   tracks per-monitor run lengths, the sticky flag and the pending report.
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_cyt_rdma_hls_deadlock_reporter;

    localparam int NUM_MON = 8;
    localparam int CNT_W   = 16;
    localparam int STAMP_W = 32;

    logic               clock;
    logic               reset;
    logic [NUM_MON-1:0] mon_block;
`ifdef CYT_RDMA_DEADLOCK_MASK_EN
    logic [NUM_MON-1:0] mon_mask;
`endif
    logic [CNT_W-1:0]   threshold;
    logic               clear;
    logic               rpt_valid;
    logic               rpt_ready;
    logic [4:0]         rpt_mon_id;
    logic [STAMP_W-1:0] rpt_stamp;
    logic               deadlock;
    logic               block_any;

    int n_cmp;
    int n_bad;

    // Behavioural model state.
    int                 run [NUM_MON];
    bit                 m_dl;
    bit                 m_valid;
    bit                 m_blk_any;
    int                 m_id;
    logic [STAMP_W-1:0] m_stamp;
    logic [STAMP_W-1:0] m_time;

    cyt_rdma_hls_deadlock_reporter #(
        .NUM_MON (NUM_MON),
        .CNT_W   (CNT_W),
        .STAMP_W (STAMP_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .mon_block  (mon_block),
`ifdef CYT_RDMA_DEADLOCK_MASK_EN
        .mon_mask   (mon_mask),
`endif
        .threshold  (threshold),
        .clear      (clear),
        .rpt_valid  (rpt_valid),
        .rpt_ready  (rpt_ready),
        .rpt_mon_id (rpt_mon_id),
        .rpt_stamp  (rpt_stamp),
        .deadlock   (deadlock),
        .block_any  (block_any)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [NUM_MON-1:0] active_blocks();
`ifdef CYT_RDMA_DEADLOCK_MASK_EN
        return mon_block & ~mon_mask;
`else
        return mon_block;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_MON; i++) run[i] = 0;
        m_dl      = 1'b0;
        m_valid   = 1'b0;
        m_blk_any = 1'b0;
        m_id      = 0;
        m_stamp   = '0;
        m_time    = '0;
    endtask

    // One clock edge of the reporter, expressed as rules on run lengths.
    task automatic model_step();
        logic [NUM_MON-1:0] act;
        int winner;
        act = active_blocks();
        if (!m_dl) begin
            if (clear) begin
                for (int i = 0; i < NUM_MON; i++) run[i] = 0;
            end else begin
                winner = -1;
                for (int i = 0; i < NUM_MON; i++)
                    if (winner < 0 && threshold != 0 && run[i] >= int'(threshold)) winner = i;
                if (winner >= 0) begin
                    m_dl    = 1'b1;
                    m_valid = 1'b1;
                    m_id    = winner;
                    m_stamp = m_time;
                end
                for (int i = 0; i < NUM_MON; i++)
                    run[i] = act[i] ? ((run[i] < 65535) ? run[i] + 1 : run[i]) : 0;
            end
        end else if (m_valid) begin
            if (rpt_ready) m_valid = 1'b0;
        end else if (clear) begin
            m_dl = 1'b0;
            for (int i = 0; i < NUM_MON; i++) run[i] = 0;
        end
        m_blk_any = |act;
        m_time    = m_time + 1;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic rearm();
        mon_block = '0;
        rpt_ready = 1'b1;
        clear     = 1'b0;
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (rpt_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", rpt_valid); end
        n_cmp++; if (deadlock !== 1'b0) begin n_bad++; $display("FAIL reset_deadlock: got %b expected 0", deadlock); end
        n_cmp++; if (block_any !== 1'b0) begin n_bad++; $display("FAIL reset_block_any: got %b expected 0", block_any); end
        n_cmp++; if (rpt_mon_id !== 5'd0) begin n_bad++; $display("FAIL reset_mon_id: got %0d expected 0", rpt_mon_id); end
        n_cmp++; if (rpt_stamp !== '0) begin n_bad++; $display("FAIL reset_stamp: got %0h expected 0", rpt_stamp); end
        @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_single_detect();
        logic [STAMP_W-1:0] t0;
        int beats;
        rearm();
        threshold    = 16'd4;
        rpt_ready    = 1'b1;
        t0           = m_time;
        mon_block[3] = 1'b1;
        beats        = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (rpt_valid === 1'b1) beats++;
            n_cmp++;
            if (deadlock !== (k >= 5)) begin
                n_bad++; $display("FAIL single_deadlock t%0d: got %b expected %b", k, deadlock, (k >= 5));
            end
            if (k == 5) begin
                n_cmp++; if (rpt_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b expected 1", rpt_valid); end
                n_cmp++; if (rpt_mon_id !== 5'd3) begin n_bad++; $display("FAIL single_mon_id: got %0d expected 3", rpt_mon_id); end
                n_cmp++; if (rpt_stamp !== t0 + 4) begin n_bad++; $display("FAIL single_stamp: got %0d expected %0d", rpt_stamp, t0 + 4); end
            end
        end
        n_cmp++; if (beats != 1) begin n_bad++; $display("FAIL single_beats: got %0d expected 1", beats); end
        mon_block = '0;
        clear     = 1'b1;
        tick();
        clear = 1'b0;
        n_cmp++; if (deadlock !== 1'b0) begin n_bad++; $display("FAIL single_clear: got %b expected 0", deadlock); end
    endtask

    task automatic test_glitch();
        bit pat [9] = '{1, 1, 1, 0, 1, 1, 1, 0, 0};
        rearm();
        threshold = 16'd4;
        for (int k = 0; k < 9; k++) begin
            mon_block[2] = pat[k];
            tick();
            n_cmp++; if (deadlock !== 1'b0) begin n_bad++; $display("FAIL glitch_deadlock t%0d: got %b expected 0", k, deadlock); end
            n_cmp++; if (block_any !== pat[k]) begin n_bad++; $display("FAIL glitch_block_any t%0d: got %b expected %b", k, block_any, pat[k]); end
        end
    endtask

    task automatic test_simultaneous();
        int beats;
        rearm();
        threshold = 16'd2;
        mon_block = 8'b0010_0010;
        beats     = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (rpt_valid === 1'b1) beats++;
            if (k == 3) begin
                n_cmp++; if (deadlock !== 1'b1) begin n_bad++; $display("FAIL simul_deadlock: got %b expected 1", deadlock); end
                n_cmp++; if (rpt_mon_id !== 5'd1) begin n_bad++; $display("FAIL simul_mon_id: got %0d expected 1", rpt_mon_id); end
            end
        end
        n_cmp++; if (beats != 1) begin n_bad++; $display("FAIL simul_beats: got %0d expected 1", beats); end
        rearm();
    endtask

    task automatic test_backpressure_clear();
        bit found;
        logic [STAMP_W-1:0] exp_stamp;
        rearm();
        threshold    = 16'd3;
        rpt_ready    = 1'b0;
        mon_block[6] = 1'b1;
        found        = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (rpt_valid === 1'b1) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL bp_detect: got rpt_valid 0 expected 1 within 10 cycles"); end
        exp_stamp = m_stamp;
        for (int k = 1; k <= 20; k++) begin
            clear = (k == 7);
            tick();
            n_cmp++; if (rpt_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid t%0d: got %b expected 1", k, rpt_valid); end
            n_cmp++; if (deadlock !== 1'b1) begin n_bad++; $display("FAIL bp_deadlock t%0d: got %b expected 1", k, deadlock); end
            n_cmp++; if (rpt_mon_id !== 5'd6) begin n_bad++; $display("FAIL bp_mon_id t%0d: got %0d expected 6", k, rpt_mon_id); end
            n_cmp++; if (rpt_stamp !== exp_stamp) begin n_bad++; $display("FAIL bp_stamp t%0d: got %0d expected %0d", k, rpt_stamp, exp_stamp); end
        end
        clear     = 1'b0;
        rpt_ready = 1'b1;
        tick();
        n_cmp++; if (rpt_valid !== 1'b0) begin n_bad++; $display("FAIL bp_accept_valid: got %b expected 0", rpt_valid); end
        n_cmp++; if (deadlock !== 1'b1) begin n_bad++; $display("FAIL bp_hold_deadlock: got %b expected 1", deadlock); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_cmp++; if (deadlock !== 1'b0) begin n_bad++; $display("FAIL bp_clear: got %b expected 0", deadlock); end
        // Block is still high: counters restart from 0, so the next detection
        // lands exactly threshold+1 edges after the clear.
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_cmp++;
            if (deadlock !== (k == 4)) begin
                n_bad++; $display("FAIL bp_rearm t%0d: got %b expected %b", k, deadlock, (k == 4));
            end
        end
        rearm();
    endtask

    task automatic test_async_reset();
        bit found;
        rearm();
        threshold    = 16'd2;
        rpt_ready    = 1'b0;
        mon_block[4] = 1'b1;
        found        = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (rpt_valid === 1'b1) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL areset_detect: got rpt_valid 0 expected 1 within 10 cycles"); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (rpt_valid !== 1'b0) begin n_bad++; $display("FAIL areset_valid: got %b expected 0", rpt_valid); end
        n_cmp++; if (deadlock !== 1'b0) begin n_bad++; $display("FAIL areset_deadlock: got %b expected 0", deadlock); end
        n_cmp++; if (rpt_stamp !== '0) begin n_bad++; $display("FAIL areset_stamp: got %0h expected 0", rpt_stamp); end
        mon_block = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        mon_block[0] = 1'b1;
        rpt_ready    = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_cmp++;
            if (deadlock !== (k == 3)) begin
                n_bad++; $display("FAIL areset_rearm t%0d: got %b expected %b", k, deadlock, (k == 3));
            end
        end
        n_cmp++; if (rpt_mon_id !== 5'd0) begin n_bad++; $display("FAIL areset_mon_id: got %0d expected 0", rpt_mon_id); end
        rearm();
    endtask

`ifdef CYT_RDMA_DEADLOCK_MASK_EN
    task automatic test_mask();
        rearm();
        mon_mask  = 8'h01;
        threshold = 16'd8;
        mon_block = 8'h01;
        for (int k = 0; k < 100; k++) begin
            tick();
            n_cmp++; if (deadlock !== 1'b0) begin n_bad++; $display("FAIL mask_deadlock t%0d: got %b expected 0", k, deadlock); end
            n_cmp++; if (block_any !== 1'b0) begin n_bad++; $display("FAIL mask_block_any t%0d: got %b expected 0", k, block_any); end
        end
        mon_mask = '0;
        rearm();
    endtask
`endif

    task automatic test_random();
        rearm();
        threshold = 16'd3;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < NUM_MON; i++)
                if ($urandom_range(0, 5) == 0) mon_block[i] = ~mon_block[i];
            if ($urandom_range(0, 49) == 0) threshold = CNT_W'($urandom_range(0, 6));
            rpt_ready = 1'($urandom_range(0, 1));
            clear     = ($urandom_range(0, 15) == 0);
            tick();
            n_cmp++; if (rpt_valid !== m_valid) begin n_bad++; $display("FAIL rand_valid c%0d: got %b expected %b", k, rpt_valid, m_valid); end
            n_cmp++; if (deadlock !== m_dl) begin n_bad++; $display("FAIL rand_deadlock c%0d: got %b expected %b", k, deadlock, m_dl); end
            n_cmp++; if (block_any !== m_blk_any) begin n_bad++; $display("FAIL rand_block_any c%0d: got %b expected %b", k, block_any, m_blk_any); end
            if (m_valid) begin
                n_cmp++; if (rpt_mon_id !== 5'(m_id)) begin n_bad++; $display("FAIL rand_mon_id c%0d: got %0d expected %0d", k, rpt_mon_id, m_id); end
                n_cmp++; if (rpt_stamp !== m_stamp) begin n_bad++; $display("FAIL rand_stamp c%0d: got %0d expected %0d", k, rpt_stamp, m_stamp); end
            end
        end
        clear = 1'b0;
        rearm();
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b0;
        clear     = 1'b0;
        rpt_ready = 1'b1;
        mon_block = '0;
        threshold = '0;
`ifdef CYT_RDMA_DEADLOCK_MASK_EN
        mon_mask  = '0;
`endif
        model_reset();
        test_reset();
        test_single_detect();
        test_glitch();
        test_simultaneous();
        test_backpressure_clear();
        test_async_reset();
`ifdef CYT_RDMA_DEADLOCK_MASK_EN
        test_mask();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
